// File: rtl/param_multicycle_cpu.sv
// Parametrised multicycle bus processor: configurable width and register count,
// run/done/busy handshake, Z/C flags, cmp and mvnz, back-to-back issue.
module param_multicycle_cpu #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] final_out,
  output logic              z_flag,
  output logic              c_flag
);
  localparam int IR_W = 2*REG_AW + 3;

  typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_e;
  typedef enum logic [2:0] {
    OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MVNZ, OP_CMP
  } op_e;

  state_e            state_q;
  logic [IR_W-1:0]   ir_q;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] a_q, g_q, final_q;
  logic              busy_q, done_q, z_q, c_q;

  op_e               op;
  logic [REG_AW-1:0] rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val;
  logic [DATA_W-1:0] g_d;
  logic              c_d;

  // Only the low opcode/Rx/Ry field of the instruction word is kept.
  assign op     = op_e'(ir_q[IR_W-1 -: 3]);
  assign rx     = ir_q[2*REG_AW-1 -: REG_AW];
  assign ry     = ir_q[REG_AW-1:0];
  assign rx_val = regs_q[rx];
  assign ry_val = regs_q[ry];

  // ALU result for the T2 step; the extra top bit is carry for add, borrow for sub/cmp.
  always_comb begin
    g_d = '0;
    c_d = 1'b0;
    case (op)
      OP_ADD:         {c_d, g_d} = {1'b0, a_q} + {1'b0, ry_val};
      OP_SUB, OP_CMP: {c_d, g_d} = {1'b0, a_q} - {1'b0, ry_val};
      OP_AND:         g_d = a_q & ry_val;
      OP_XOR:         g_d = a_q ^ ry_val;
      default:        ;
    endcase
  end

  // Control FSM plus datapath registers; every completing step returns to IDLE
  // and raises done, so run can be accepted in the very next (done) cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      final_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (run) begin
            ir_q    <= data_in[IR_W-1:0];
            state_q <= S_T1;
            busy_q  <= 1'b1;
          end
        end
        S_T1: begin
          case (op)
            OP_MV, OP_MVI, OP_MVNZ: begin
              // Single-step moves; mvnz skips both the write and final_out on Z.
              if (op == OP_MVI) begin
                regs_q[rx] <= data_in;
                final_q    <= data_in;
              end else if (op == OP_MV || !z_q) begin
                regs_q[rx] <= ry_val;
                final_q    <= ry_val;
              end
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
            default: begin
              a_q     <= rx_val;
              state_q <= S_T2;
            end
          endcase
        end
        S_T2: begin
          g_q <= g_d;
          z_q <= (g_d == '0);
          c_q <= c_d;
          if (op == OP_CMP) begin
            final_q <= g_d;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_T3;
          end
        end
        S_T3: begin
          regs_q[rx] <= g_q;
          final_q    <= g_q;
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign final_out = final_q;
  assign z_flag    = z_q;
  assign c_flag    = c_q;
endmodule
